// File: rtl/midi_pkg.sv
// Shared MIDI byte-class constants, parser state encoding and the status-to-length lookup.
// Used by midi_msg_parser (optional running status: MIDI_RUNNING_STATUS_EN) and later decode stages.
package midi_pkg;

    localparam logic [7:0] STATUS_MIN  = 8'h80;
    localparam logic [7:0] RT_MIN      = 8'hF8;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } midi_state_e;

    typedef struct packed {
        logic       defined;
        logic [1:0] len;
    } midi_len_t;

    // F0 and F7 report undefined here; the parser gives them their SysEx meaning.
    function automatic midi_len_t midi_data_len(input logic [7:0] status);
        midi_len_t r;
        r.defined = 1'b1;
        r.len     = 2'd0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: r.len = 2'd2;
            4'hC, 4'hD:                   r.len = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h1, 4'h3: r.len = 2'd1;
                    4'h2:       r.len = 2'd2;
                    4'h6:       r.len = 2'd0;
                    default:    r.defined = 1'b0;
                endcase
            end
            default: r.defined = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/midi_len_decode.sv
// Combinational status byte to data-byte count lookup, with a flag for defined statuses.
module midi_len_decode
    import midi_pkg::*;
(
    input  logic [7:0] status_i,
    output logic [1:0] len_o,
    output logic       defined_o
);

    midi_len_t info_s;

    // Table lookup via the shared package function.
    always_comb begin
        info_s    = midi_data_len(status_i);
        len_o     = info_s.len;
        defined_o = info_s.defined;
    end

endmodule

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel / system-common messages from received bytes; real-time bytes pass through.
// Define MIDI_RUNNING_STATUS_EN to keep channel status across messages (running status).
module midi_msg_parser
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       framing_err,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       drop
);

    midi_state_e state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [1:0]  len_q, len_d;
    logic [6:0]  data1_q, data1_d;
    logic        msg_valid_q, msg_valid_d;
    logic [7:0]  msg_status_q, msg_status_d;
    logic [6:0]  msg_data1_q, msg_data1_d;
    logic [6:0]  msg_data2_q, msg_data2_d;
    logic [1:0]  msg_len_q, msg_len_d;
    logic        rt_valid_q, rt_valid_d;
    logic [7:0]  rt_byte_q, rt_byte_d;
    logic        drop_q, drop_d;

    logic [1:0]  dec_len_s;
    logic        dec_defined_s;
    logic        is_rt_s;
    logic        is_status_s;
    logic        keep_status_s;

    midi_len_decode u_len_decode (
        .status_i  (byte_in),
        .len_o     (dec_len_s),
        .defined_o (dec_defined_s)
    );

    assign is_rt_s     = (byte_in >= RT_MIN);
    assign is_status_s = (byte_in >= STATUS_MIN) && !is_rt_s;
`ifdef MIDI_RUNNING_STATUS_EN
    assign keep_status_s = (status_q[7:4] != 4'hF);
`else
    assign keep_status_s = 1'b0;
`endif

    // Next-state and output computation for one received byte.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        len_d        = len_q;
        data1_d      = data1_q;
        msg_valid_d  = 1'b0;
        msg_status_d = msg_status_q;
        msg_data1_d  = msg_data1_q;
        msg_data2_d  = msg_data2_q;
        msg_len_d    = msg_len_q;
        rt_valid_d   = 1'b0;
        rt_byte_d    = rt_byte_q;
        drop_d       = 1'b0;

        if (byte_valid) begin
            if (framing_err) begin
                drop_d   = 1'b1;
                state_d  = IDLE;
                status_d = 8'h00;
            end else if (is_rt_s) begin
                rt_valid_d = 1'b1;
                rt_byte_d  = byte_in;
            end else if (is_status_s) begin
                // Any status byte abandons a partial message without a drop.
                if ((state_q == SYSEX) && (byte_in == SYSEX_END)) begin
                    state_d  = IDLE;
                    status_d = 8'h00;
                end else if (byte_in == SYSEX_START) begin
                    state_d  = SYSEX;
                    status_d = 8'h00;
                end else if (!dec_defined_s) begin
                    drop_d   = 1'b1;
                    state_d  = IDLE;
                    status_d = 8'h00;
                end else if (dec_len_s == 2'd0) begin
                    msg_valid_d  = 1'b1;
                    msg_status_d = byte_in;
                    msg_data1_d  = 7'd0;
                    msg_data2_d  = 7'd0;
                    msg_len_d    = 2'd0;
                    state_d      = IDLE;
                    status_d     = 8'h00;
                end else begin
                    status_d = byte_in;
                    len_d    = dec_len_s;
                    state_d  = WAIT_D1;
                end
            end else begin
                case (state_q)
                    IDLE: drop_d = 1'b1;
                    WAIT_D1: begin
                        if (len_q == 2'd1) begin
                            msg_valid_d  = 1'b1;
                            msg_status_d = status_q;
                            msg_data1_d  = byte_in[6:0];
                            msg_data2_d  = 7'd0;
                            msg_len_d    = 2'd1;
                            state_d      = keep_status_s ? WAIT_D1 : IDLE;
                            status_d     = keep_status_s ? status_q : 8'h00;
                        end else begin
                            data1_d = byte_in[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        msg_valid_d  = 1'b1;
                        msg_status_d = status_q;
                        msg_data1_d  = data1_q;
                        msg_data2_d  = byte_in[6:0];
                        msg_len_d    = 2'd2;
                        state_d      = keep_status_s ? WAIT_D1 : IDLE;
                        status_d     = keep_status_s ? status_q : 8'h00;
                    end
                    SYSEX:   state_d = SYSEX;
                    default: state_d = IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Parser state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            status_q     <= 8'h00;
            len_q        <= 2'd0;
            data1_q      <= 7'd0;
            msg_valid_q  <= 1'b0;
            msg_status_q <= 8'h00;
            msg_data1_q  <= 7'd0;
            msg_data2_q  <= 7'd0;
            msg_len_q    <= 2'd0;
            rt_valid_q   <= 1'b0;
            rt_byte_q    <= 8'h00;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            len_q        <= len_d;
            data1_q      <= data1_d;
            msg_valid_q  <= msg_valid_d;
            msg_status_q <= msg_status_d;
            msg_data1_q  <= msg_data1_d;
            msg_data2_q  <= msg_data2_d;
            msg_len_q    <= msg_len_d;
            rt_valid_q   <= rt_valid_d;
            rt_byte_q    <= rt_byte_d;
            drop_q       <= drop_d;
        end
    end

    assign msg_valid  = msg_valid_q;
    assign msg_status = msg_status_q;
    assign msg_data1  = msg_data1_q;
    assign msg_data2  = msg_data2_q;
    assign msg_len    = msg_len_q;
    assign rt_valid   = rt_valid_q;
    assign rt_byte    = rt_byte_q;
    assign drop       = drop_q;

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Downstream stage of the MIDI receiver: consumes the stream of deserialized bytes and assembles complete MIDI channel and system-common messages. It emits one registered message strobe per complete message and passes real-time bytes straight through. Its output feeds the note/controller decode logic.

## Interface
Parameters:
- none; all widths are fixed by the MIDI protocol.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low
- byte_in  input  8  received byte; valid only while byte_valid=1
- byte_valid  input  1  one-cycle strobe per received byte
- framing_err  input  1  qualifies byte_valid; the byte had a bad stop bit
- msg_valid  output  1  one-cycle pulse; message fields are valid
- msg_status  output  8  status byte of the message
- msg_data1  output  7  first data byte (0 if msg_len=0)
- msg_data2  output  7  second data byte (0 if msg_len<2)
- msg_len  output  2  number of data bytes: 0, 1 or 2
- rt_valid  output  1  one-cycle pulse; a real-time byte was received
- rt_byte  output  8  real-time byte (0xF8–0xFF)
- drop  output  1  one-cycle pulse; a byte was discarded

## Operation
- Byte classes: data is 0x00–0x7F; status is 0x80–0xF7; real-time is 0xF8–0xFF.
- Data-byte counts:
  - 8n, 9n, An, Bn, En: 2
  - Cn, Dn, F1, F3: 1
  - F2: 2
  - F6: 0
- F4 and F5 are undefined and are dropped. F7 outside SysEx is dropped.
- States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- Status byte of length 0 (F6): emit immediately, then go to IDLE.
- Other valid status byte: latch it in status_q and go to WAIT_D1.
- F0: go to SYSEX. SYSEX discards data bytes silently, leaves on F7 to IDLE, and leaves on any other status byte, which is then processed normally.
- WAIT_D1 with a data byte:
  - length 1: emit the message.
  - length 2: latch data1 and go to WAIT_D2.
- WAIT_D2 with a data byte: emit the message.
- Status byte in WAIT_D1/WAIT_D2: the partial message is abandoned without a drop pulse, and the new status byte is processed.
- Real-time bytes in any state: pulse rt_valid with rt_byte. State, status_q and data1 are untouched.
- A data byte in IDLE is dropped and pulses drop.
- framing_err=1 with byte_valid: the byte is ignored, drop pulses, state goes to IDLE, and status_q is cleared.
- System-common messages (F1–F6) always clear running status after they are emitted.

## Timing
- All outputs are registered.
- msg_valid, rt_valid and drop assert in the cycle after the byte_valid that caused them, for exactly one cycle.
- msg_* and rt_byte hold their values until the next pulse.
- Back-to-back byte_valid on consecutive cycles is supported at full rate.
- The parser never stalls and has no backpressure.
- Reset (asynchronous, mid-message included): state=IDLE, status_q=0, all outputs 0. There are no pulses in the first cycle after deassertion.

## Configuration
- MIDI_RUNNING_STATUS_EN defined: after a channel message (8n–En) is emitted, state returns to WAIT_D1 with status_q kept. Following data bytes form new messages with the same status.
- Undefined: after any emit, state returns to IDLE and status_q clears. Data bytes without a fresh status are dropped and pulse drop.

## Structure
- Shared package midi_pkg holds:
  - byte-class constants: STATUS_MIN=8'h80, RT_MIN=8'hF8, SYSEX_START=8'hF0, SYSEX_END=8'hF7
  - the state enum
  - function midi_data_len(status) returning 2 bits plus a defined flag
- One sub-module, midi_len_decode: combinational status→length/defined lookup, reused by later stages.

## Test plan
- 90 3C 64 → one msg_valid with status 0x90, d1 0x3C, d2 0x64, len 2, in the cycle after the third byte_valid.
- With MIDI_RUNNING_STATUS_EN, 90 3C 64 3E 00 → two messages, the second 0x90/0x3E/0x00. Without it, the second pair produces two drop pulses.
- 90 3C F8 64 → rt_valid with 0xF8 after byte 3, then msg 0x90/0x3C/0x64 after byte 4.
- F0 01 02 7F F7 C5 12 → no message until msg 0xC5/0x12, len 1.
- B0 07 with framing_err on byte 2, then 40 → drop, drop, no msg_valid.
- 90 3C, reset asserted, release, 64 → outputs 0 during reset; 64 pulses drop.
